if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//   Instruction fetch stage: owns the PC and issues single-outstanding requests
//   to instruction memory. Delivers each fetched word and its PC+4 to the IF/ID
//   pipeline register as a registered instruction/pc pair. Stall holds the output,
//   a branch/jump redirect flushes it and re-steers the PC.
//   Zero-wait memory sustains one instruction per cycle.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
// PORTS
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous, active-high reset
//   stall          in   1   downstream hazard stall; hold instr_out/pc4_out
//   redirect_valid in   1   branch/jump taken; priority over stall
//   redirect_pc    in   32  redirect target; bits [1:0] ignored (treated as 0)
//   imem_req       out  1   fetch request; imem_addr stable while high and !imem_ready
//   imem_addr      out  32  fetch address (= pc)
//   imem_ready     in   1   response valid this cycle; meaningful only when imem_req=1
//   imem_rdata     in   32  instruction word, valid with imem_ready
//   instr_out      out  32  instruction to IF/ID; 32'h0 (NOP) when no valid instruction
//   pc4_out        out  32  PC+4 of instr_out; 32'h0 when instr_valid=0
//   instr_valid    out  1   instr_out holds a real fetched instruction
// BEHAVIOUR
//   Reset: pc=RESET_PC, state=REQ, skid empty, instr_out=0, pc4_out=0,
//     instr_valid=0, imem_req=0 during the reset cycle, 1 on the first cycle after reset.
//   PC arithmetic: 32-bit, mod 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0.
//   States:
//     REQ     imem_req=1, imem_addr=pc.
//             ready & !stall  -> out<=(rdata,pc+4,valid=1), pc<=pc+4, stay REQ.
//             ready & stall   -> skid<=(rdata,pc+4), pc<=pc+4, go HOLD; out held.
//             !ready          -> if !stall out<=(0,0,valid=0) (bubble); stay REQ.
//     HOLD    imem_req=0. stall -> hold everything.
//             !stall -> out<=skid (valid=1), skid cleared, go REQ.
//     DISCARD imem_req=1, imem_addr = old in-flight address (kept stable);
//             response on ready is dropped, then go REQ with the redirected pc.
//             out stays (0,0,0) throughout.
//   Redirect (any state, any stall value), same edge:
//     pc<=redirect_pc&~3, skid cleared, out<=(0,0,valid=0).
//     REQ & !ready -> DISCARD (in-flight request completes, data dropped).
//     REQ & ready  -> response dropped, stay REQ; next cycle imem_addr=new pc.
//     HOLD -> REQ. DISCARD -> stay DISCARD; pc takes the newest target.
//   stall=1 with no redirect never alters instr_out/pc4_out/instr_valid.
//   Latency: imem_ready at edge N (not stalled) -> instr_out valid after edge N.
//   At most one request outstanding; skid depth exactly 1.
//   Reset mid-request: outstanding response discarded; memory must tolerate
//     imem_req dropping without ready.
// TESTING
//   1 Reset, ready tied 1, imem_rdata=addr^32'hA5A5_0000 -> instr_out sequence
//     for pc 0,4,8 on consecutive cycles, pc4_out=4,8,12, instr_valid=1 each cycle.
//   2 ready delayed 3 cycles on pc=8 -> imem_addr=8 stable 3 cycles, 3 NOP bubbles
//     (valid=0), then instr_out=word@8, pc4_out=12.
//   3 stall=1 same cycle ready returns word@12 -> output still word@8 while stalled,
//     imem_req=0 (HOLD); stall drops -> instr_out=word@12, pc4_out=16, next imem_addr=16.
//   4 redirect_valid, redirect_pc=32'h0000_0103 while pc=20 request pending ->
//     instr_valid=0, imem_addr stays 20 until ready, word@20 never appears,
//     then imem_addr=32'h100.
//   5 RESET_PC=32'hFFFF_FFF8, ready=1 -> pc4_out FFFF_FFFC, 0, 4; addr wraps to 0.
//   6 redirect and stall asserted together in HOLD -> skid dropped, out=(0,0,0),
//     next imem_addr=redirect target.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time
// and registers each fetched word with its PC+4 for the IF/ID boundary.
//
// state   | meaning
// S_REQ   | request at pc outstanding; response goes to output or skid
// S_HOLD  | skid holds one fetched word while downstream is stalled; no request
// S_DISCARD | request issued before a redirect still in flight; its data is dropped
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_out_o,
   output logic [31:0] pc4_out_o,
   output logic        instr_valid_o
);

   typedef enum logic [1:0] {S_REQ, S_HOLD, S_DISCARD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] disc_addr_q, disc_addr_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc4_q, skid_pc4_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         disc_addr_q  <= RESET_PC;
         skid_instr_q <= 32'h0;
         skid_pc4_q   <= 32'h0;
         instr_q      <= 32'h0;
         pc4_q        <= 32'h0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         disc_addr_q  <= disc_addr_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
         instr_q      <= instr_d;
         pc4_q        <= pc4_d;
         valid_q      <= valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      disc_addr_d  = disc_addr_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;
      instr_d      = instr_q;
      pc4_d        = pc4_q;
      valid_d      = valid_q;

      case (state_q)
         S_REQ: begin
            if (imem_ready_i) begin
               pc_d = pc_plus4;
               if (stall_i) begin
                  skid_instr_d = imem_rdata_i;
                  skid_pc4_d   = pc_plus4;
                  state_d      = S_HOLD;
               end else begin
                  instr_d = imem_rdata_i;
                  pc4_d   = pc_plus4;
                  valid_d = 1'b1;
               end
            end else if (!stall_i) begin
               instr_d = 32'h0;
               pc4_d   = 32'h0;
               valid_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (!stall_i) begin
               instr_d      = skid_instr_q;
               pc4_d        = skid_pc4_q;
               valid_d      = 1'b1;
               skid_instr_d = 32'h0;
               skid_pc4_d   = 32'h0;
               state_d      = S_REQ;
            end
         end
         S_DISCARD: begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
            if (imem_ready_i) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase

      // Redirect overrides everything; a request still in flight must finish before a new one.
      if (redirect_valid_i) begin
         pc_d         = {redirect_pc_i[31:2], 2'b00};
         skid_instr_d = 32'h0;
         skid_pc4_d   = 32'h0;
         instr_d      = 32'h0;
         pc4_d        = 32'h0;
         valid_d      = 1'b0;
         state_d      = S_REQ;
         if (state_q == S_REQ && !imem_ready_i) begin
            disc_addr_d = pc_q;
            state_d     = S_DISCARD;
         end else if (state_q == S_DISCARD && !imem_ready_i) begin
            state_d = S_DISCARD;
         end
      end
   end

   assign imem_req_o    = !reset_i && (state_q != S_HOLD);
   assign imem_addr_o   = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
   assign instr_out_o   = instr_q;
   assign pc4_out_o     = pc4_q;
   assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run checked against
// a transaction-level model (pending-drop flag, skid queue, output triple).
module tb_if_fetch_unit;

   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset, stall, redirect_valid, imem_ready;
   logic [31:0] redirect_pc;
   logic        req1, req2, valid1, valid2;
   logic [31:0] addr1, addr2, rdata1, rdata2, instr1, instr2, pc4_1, pc4_2;

   int passed = 0;
   int total  = 0;

   // model state
   logic [31:0] m_pc, m_drop_addr, m_instr, m_pc4;
   logic        m_drop, m_valid;
   logic [63:0] m_skid[$];

   always #5 clk = ~clk;

   assign rdata1 = addr1 ^ K;
   assign rdata2 = addr2 ^ K;

   if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i(clk), .reset_i(reset), .stall_i(stall),
      .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
      .imem_req_o(req1), .imem_addr_o(addr1),
      .imem_ready_i(imem_ready), .imem_rdata_i(rdata1),
      .instr_out_o(instr1), .pc4_out_o(pc4_1), .instr_valid_o(valid1)
   );

   if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk_i(clk), .reset_i(reset), .stall_i(stall),
      .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
      .imem_req_o(req2), .imem_addr_o(addr2),
      .imem_ready_i(imem_ready), .imem_rdata_i(rdata2),
      .instr_out_o(instr2), .pc4_out_o(pc4_2), .instr_valid_o(valid2)
   );

   task automatic edge_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b0;
      edge_tick();
      edge_tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b0;
      edge_tick();
      edge_tick();
      total++; if (req1 !== 1'b0) $display("FAIL reset_req: got %b want 0", req1); else passed++;
      total++; if ({instr1, pc4_1, valid1} !== 65'h0)
         $display("FAIL reset_out: got %h/%h/%b want 0/0/0", instr1, pc4_1, valid1); else passed++;
      reset = 1'b0;
      #1;
      total++; if (req1 !== 1'b1 || addr1 !== 32'h0)
         $display("FAIL reset_first_req: got req=%b addr=%h want 1/0", req1, addr1); else passed++;
   endtask

   task automatic test_stream();
      imem_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         edge_tick();
         total++;
         if (instr1 !== (32'(4*k) ^ K) || pc4_1 !== 32'(4*k+4) || valid1 !== 1'b1 || addr1 !== 32'(4*k+4))
            $display("FAIL stream_%0d: got %h/%h/%b addr=%h want %h/%h/1 addr=%h", k, instr1, pc4_1, valid1,
                     addr1, 32'(4*k) ^ K, 32'(4*k+4), 32'(4*k+4));
         else passed++;
      end
   endtask

   task automatic test_wait_states();
      do_reset();
      imem_ready = 1'b1;
      edge_tick();
      edge_tick();
      imem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (req1 !== 1'b1 || addr1 !== 32'h8)
            $display("FAIL wait_addr_%0d: got req=%b addr=%h want 1/8", k, req1, addr1); else passed++;
         edge_tick();
         total++; if (valid1 !== 1'b0 || instr1 !== 32'h0 || pc4_1 !== 32'h0)
            $display("FAIL wait_bubble_%0d: got %h/%h/%b want 0/0/0", k, instr1, pc4_1, valid1); else passed++;
      end
      imem_ready = 1'b1;
      edge_tick();
      total++; if (instr1 !== (32'h8 ^ K) || pc4_1 !== 32'hC || valid1 !== 1'b1)
         $display("FAIL wait_deliver: got %h/%h/%b want %h/c/1", instr1, pc4_1, valid1, 32'h8 ^ K); else passed++;
   endtask

   task automatic test_stall_skid();
      imem_ready = 1'b1; stall = 1'b1;
      edge_tick();
      total++; if (instr1 !== (32'h8 ^ K) || pc4_1 !== 32'hC || valid1 !== 1'b1 || req1 !== 1'b0)
         $display("FAIL stall_hold: got %h/%h/%b req=%b want %h/c/1 req=0", instr1, pc4_1, valid1, req1, 32'h8 ^ K);
      else passed++;
      imem_ready = 1'b0;
      edge_tick();
      total++; if (instr1 !== (32'h8 ^ K) || pc4_1 !== 32'hC || req1 !== 1'b0)
         $display("FAIL stall_hold2: got %h/%h req=%b want %h/c req=0", instr1, pc4_1, req1, 32'h8 ^ K); else passed++;
      stall = 1'b0;
      edge_tick();
      total++; if (instr1 !== (32'hC ^ K) || pc4_1 !== 32'h10 || valid1 !== 1'b1 || req1 !== 1'b1 || addr1 !== 32'h10)
         $display("FAIL stall_release: got %h/%h/%b req=%b addr=%h want %h/10/1 req=1 addr=10",
                  instr1, pc4_1, valid1, req1, addr1, 32'hC ^ K);
      else passed++;
   endtask

   task automatic test_redirect_pending();
      imem_ready = 1'b1;
      edge_tick();
      imem_ready = 1'b0;
      edge_tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      edge_tick();
      redirect_valid = 1'b0;
      total++; if (valid1 !== 1'b0 || pc4_1 !== 32'h0 || addr1 !== 32'h14 || req1 !== 1'b1)
         $display("FAIL redir_discard: got valid=%b pc4=%h req=%b addr=%h want 0/0/1/14", valid1, pc4_1, req1, addr1);
      else passed++;
      edge_tick();
      total++; if (addr1 !== 32'h14 || valid1 !== 1'b0)
         $display("FAIL redir_addr_stable: got addr=%h valid=%b want 14/0", addr1, valid1); else passed++;
      imem_ready = 1'b1;
      edge_tick();
      total++; if (valid1 !== 1'b0 || instr1 !== 32'h0 || addr1 !== 32'h100 || req1 !== 1'b1)
         $display("FAIL redir_drop: got %h/%b req=%b addr=%h want 0/0 req=1 addr=100", instr1, valid1, req1, addr1);
      else passed++;
      edge_tick();
      total++; if (instr1 !== (32'h100 ^ K) || pc4_1 !== 32'h104 || valid1 !== 1'b1)
         $display("FAIL redir_target: got %h/%h/%b want %h/104/1", instr1, pc4_1, valid1, 32'h100 ^ K); else passed++;
   endtask

   task automatic test_redirect_in_hold();
      imem_ready = 1'b1; stall = 1'b1;
      edge_tick();
      total++; if (req1 !== 1'b0) $display("FAIL hold_enter: got req=%b want 0", req1); else passed++;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      edge_tick();
      redirect_valid = 1'b0;
      total++; if ({instr1, pc4_1, valid1} !== 65'h0 || req1 !== 1'b1 || addr1 !== 32'h200)
         $display("FAIL hold_redir: got %h/%h/%b req=%b addr=%h want 0/0/0 req=1 addr=200",
                  instr1, pc4_1, valid1, req1, addr1);
      else passed++;
      stall = 1'b0;
      edge_tick();
      total++; if (instr1 !== (32'h200 ^ K) || pc4_1 !== 32'h204 || valid1 !== 1'b1)
         $display("FAIL hold_redir_next: got %h/%h/%b want %h/204/1", instr1, pc4_1, valid1, 32'h200 ^ K);
      else passed++;
   endtask

   task automatic test_wrap();
      do_reset();
      total++; if (addr2 !== 32'hFFFF_FFF8) $display("FAIL wrap_start: got %h want fffffff8", addr2); else passed++;
      imem_ready = 1'b1;
      edge_tick();
      total++; if (instr2 !== (32'hFFFF_FFF8 ^ K) || pc4_2 !== 32'hFFFF_FFFC || valid2 !== 1'b1)
         $display("FAIL wrap_0: got %h/%h/%b want %h/fffffffc/1", instr2, pc4_2, valid2, 32'hFFFF_FFF8 ^ K);
      else passed++;
      edge_tick();
      total++; if (pc4_2 !== 32'h0 || addr2 !== 32'h0 || instr2 !== (32'hFFFF_FFFC ^ K))
         $display("FAIL wrap_1: got pc4=%h addr=%h instr=%h want 0/0/%h", pc4_2, addr2, instr2, 32'hFFFF_FFFC ^ K);
      else passed++;
      edge_tick();
      total++; if (pc4_2 !== 32'h4 || instr2 !== K)
         $display("FAIL wrap_2: got pc4=%h instr=%h want 4/%h", pc4_2, instr2, K); else passed++;
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_drop = 1'b0; m_drop_addr = 32'h0;
      m_skid.delete();
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
   endtask

   task automatic test_random();
      logic        exp_req;
      logic [31:0] exp_addr;
      logic [63:0] word;
      do_reset();
      model_reset();
      for (int n = 0; n < 400; n++) begin
         reset          = ($urandom_range(0, 49) == 0);
         stall          = ($urandom_range(0, 9) < 3);
         redirect_valid = ($urandom_range(0, 9) == 0);
         redirect_pc    = $urandom;
         imem_ready     = ($urandom_range(0, 9) < 6);
         #1;
         exp_req  = !reset && (m_skid.size() == 0);
         exp_addr = m_drop ? m_drop_addr : m_pc;
         total++; if (req1 !== exp_req) $display("FAIL rnd_req_%0d: got %b want %b", n, req1, exp_req); else passed++;
         if (exp_req) begin
            total++; if (addr1 !== exp_addr)
               $display("FAIL rnd_addr_%0d: got %h want %h", n, addr1, exp_addr); else passed++;
         end
         if (reset) begin
            model_reset();
         end else if (redirect_valid) begin
            if (m_drop) begin
               if (imem_ready) m_drop = 1'b0;
            end else if (exp_req && !imem_ready) begin
               m_drop = 1'b1; m_drop_addr = m_pc;
            end
            m_skid.delete();
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_pc = redirect_pc & ~32'h3;
         end else if (m_skid.size() > 0) begin
            if (!stall) begin
               word = m_skid.pop_front();
               m_instr = word[63:32]; m_pc4 = word[31:0]; m_valid = 1'b1;
            end
         end else if (m_drop) begin
            if (imem_ready) m_drop = 1'b0;
         end else if (imem_ready) begin
            word = {m_pc ^ K, m_pc + 32'd4};
            m_pc = m_pc + 32'd4;
            if (stall) m_skid.push_back(word);
            else begin
               m_instr = word[63:32]; m_pc4 = word[31:0]; m_valid = 1'b1;
            end
         end else if (!stall) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         total++; if (instr1 !== m_instr || pc4_1 !== m_pc4 || valid1 !== m_valid)
            $display("FAIL rnd_out_%0d: got %h/%h/%b want %h/%h/%b", n, instr1, pc4_1, valid1, m_instr, m_pc4, m_valid);
         else passed++;
      end
      reset = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_wait_states();
      test_stall_skid();
      test_redirect_pending();
      test_redirect_in_hold();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
